// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcode, T-state and control-word definitions for the SAP sequencer
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef enum logic [5:0] {
        TS_T1 = T1,
        TS_T2 = T2,
        TS_T3 = T3,
        TS_T4 = T4,
        TS_T5 = T5,
        TS_T6 = T6
    } tstate_e;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    // Fetch is opcode-independent; execute steps use whichever opcode the caller selects.
    function automatic ctrl_t decode_ctrl(input logic [5:0] ts, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (ts)
            T1: begin c.ep = 1'b1; c.lm = 1'b1; end
            T2: c.cp = 1'b1;
            T3: begin c.ce = 1'b1; c.li = 1'b1; end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin c.ei = 1'b1; c.lm = 1'b1; end
                    OP_OUT:                 begin c.ea = 1'b1; c.lo = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA:         begin c.ce = 1'b1; c.la = 1'b1; end
                    OP_ADD, OP_SUB: begin c.ce = 1'b1; c.lb = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                case (op)
                    OP_ADD: begin c.eu = 1'b1; c.la = 1'b1; end
                    OP_SUB: begin c.eu = 1'b1; c.la = 1'b1; c.su = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// rtl/controller_sequencer_if.sv - opcode in, T-state/halt/control word out between sequencer and datapath
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halted;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    modport master (
        input  opcode,
        output t_state, halted,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );

    modport slave (
        output opcode,
        input  t_state, halted,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );
endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// rtl/controller_sequencer_ring_counter.sv - six-state one-hot ring with hold
module ring_counter
    import sap_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    output logic [5:0] state_o
);
    tstate_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= TS_T1;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!hold_i) begin
            case (state_q)
                TS_T1:   state_d = TS_T2;
                TS_T2:   state_d = TS_T3;
                TS_T3:   state_d = TS_T4;
                TS_T4:   state_d = TS_T5;
                TS_T5:   state_d = TS_T6;
                TS_T6:   state_d = TS_T1;
                default: state_d = TS_T1;
            endcase
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP control sequencer: ring timing, opcode decode and halt
module controller_sequencer
    import sap_pkg::*;
(
    input logic                    clock,
    input logic                    reset,
    controller_sequencer_if.master ctl
);
    logic [5:0] ts;
    logic       in_t4;
    logic       hold;
    logic       halted_q, halted_d;
    logic [3:0] op_q, op_d;
    logic [3:0] op_sel;
    ctrl_t      ctrl;

    assign in_t4 = (ts == T4);
    // HLT freezes the ring at T4 on the very edge that ends its T4 cycle.
    assign hold  = halted_q | (in_t4 & (ctl.opcode == OP_HLT));

    ring_counter u_ring (
        .clk_i   (clock),
        .rst_i   (reset),
        .hold_i  (hold),
        .state_o (ts)
    );

    always_comb begin
        halted_d = halted_q;
        op_d     = op_q;
        if (in_t4 && !halted_q) begin
            op_d = ctl.opcode;
            if (ctl.opcode == OP_HLT) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            halted_q <= 1'b0;
            op_q     <= '0;
        end else begin
            halted_q <= halted_d;
            op_q     <= op_d;
        end
    end

    // T4 sees the live opcode; T5/T6 only the latched copy, so late opcode changes are ignored.
    assign op_sel = in_t4 ? ctl.opcode : op_q;

    always_comb begin
        ctrl = decode_ctrl(ts, op_sel);
        if (reset || halted_q) ctrl = '0;
    end

    assign ctl.t_state = ts;
    assign ctl.halted  = halted_q;
    assign ctl.cp      = ctrl.cp;
    assign ctl.ep      = ctrl.ep;
    assign ctl.lm      = ctrl.lm;
    assign ctl.ce      = ctrl.ce;
    assign ctl.li      = ctrl.li;
    assign ctl.ei      = ctrl.ei;
    assign ctl.la      = ctrl.la;
    assign ctl.ea      = ctrl.ea;
    assign ctl.su      = ctrl.su;
    assign ctl.eu      = ctrl.eu;
    assign ctl.lb      = ctrl.lb;
    assign ctl.lo      = ctrl.lo;
endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 Parameters: none; ring length fixed at 6 T-states.
REQ-002 clock  input  1  sole clock; all state updates SHALL occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  instruction opcode from instruction register; valid from T4.
REQ-005 t_state  output  6  one-hot current T-state, bit0=T1 .. bit5=T6.
REQ-006 halted  output  1  high once HLT has executed.
REQ-007 Control outputs, 1 bit each, active-high:
- cp: PC increment.
- ep: PC to bus.
- lm: load MAR.
- ce: RAM to bus.
- li: load IR.
- ei: IR operand to bus.
- la: load A.
- ea: A to bus.
- su: ALU subtract.
- eu: ALU to bus.
- lb: load B.
- lo: load output register.

Function
REQ-008 The sequencer SHALL advance T1->T2->...->T6->T1, one state per clock, while not halted.
REQ-009 Control outputs SHALL be combinational decode of the registered state (zero added latency).
REQ-010 Fetch:
- T1: ep, lm.
- T2: cp.
- T3: ce, li.
These are independent of opcode.
REQ-011 During T4 the sequencer SHALL decode opcode directly and SHALL register it into op_q at the T4->T5 edge; T5/T6 SHALL decode from op_q only.
REQ-012 LDA (0000):
- T4: ei, lm.
- T5: ce, la.
- T6: none.
REQ-013 ADD (0001):
- T4: ei, lm.
- T5: ce, lb.
- T6: eu, la.
REQ-014 SUB (0010): as ADD, plus su asserted in T6.
REQ-015 OUT (1110):
- T4: ea, lo.
- T5, T6: none.
REQ-016 HLT (1111): in T4 all control outputs SHALL be 0; halted SHALL rise at the T4 clock edge.
REQ-017 Once halted, the state SHALL freeze at T4 and all control outputs SHALL stay 0 until reset.
REQ-018 Undefined opcodes SHALL execute as NOP: T4–T6 with all outputs 0, then return to T1.
REQ-019 At most one of ep, ce, ei, ea, eu SHALL be high in any cycle (single bus driver).
REQ-020 Opcode changes during T5/T6 SHALL have no effect on outputs.

Reset
REQ-021 When reset is high at a clock edge, the next state SHALL be as follows, regardless of current state or halted:
- t_state = 6'b000001 (T1).
- halted = 0.
- op_q = 0.
REQ-022 While reset is high, all control outputs SHALL be forced to 0.
REQ-023 Reset asserted mid-instruction SHALL abort it; the first post-reset cycle SHALL be T1 with ep and lm asserted.

Structure
REQ-024 Shared package sap_pkg SHALL hold:
- the opcode enum (LDA, ADD, SUB, OUT, HLT).
- the T-state one-hot constants.
- a packed control-word struct matching REQ-007 order.
REQ-025 The 6-bit one-hot ring with hold input SHALL be a sub-module, ring_counter; decode and halt logic SHALL stay in controller_sequencer.

Verification
REQ-026 Release reset -> cycle1: t_state=000001, ep=lm=1; cycle2: cp=1; cycle3: ce=li=1.
REQ-027 opcode=0001 -> T4 ei,lm; T5 ce,lb; T6 eu,la, su=0; cycle 7 back in T1. Repeat with opcode=0010 -> T6 su=1.
REQ-028 opcode=1111 -> halted=1 from T4 edge; t_state holds 001000 and all controls stay 0 for 20 cycles; reset -> T1.
REQ-029 opcode=0000, then opcode changed to 1110 during T5 -> T5 still ce,la; no lo asserted.
REQ-030 Reset asserted in T5 of ADD -> next cycle T1, lb never asserted; random opcodes over 1000 cycles -> bus-driver one-hot assertion never fails.
